inst_loader: RTL and testbench

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them to consecutive word addresses of the 64-word instruction RAM, starting at word 0. The CPU is held in reset while a load is in progress; the instruction-fetch unit reads the same RAM once the CPU is released.

---
 rtl/inst_loader.sv | 82 ++++++++
 tb/tb_inst_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: boot-time byte-stream loader that fills the instruction RAM
module inst_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  localparam int CAP = 2 ** ADDR_W;
  localparam int TW  = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;
  state_t          state, state_nx;
  logic [ADDR_W:0] total;
  logic [1:0]      nbytes;
  logic [TW-1:0]   idle;
  logic            xfer, go, tmo, last, len_bad;
  assign xfer    = byte_valid && (state == LEN || state == DATA);
  assign go      = start && (state == IDLE || state == DONE || state == ERR);
  assign tmo     = !xfer && idle == TW'(TIMEOUT - 1);
  assign last    = word_count + (ADDR_W + 1)'(1) == total;
  assign len_bad = int'(byte_data) > CAP;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  // next state and state-decoded outputs
  always_comb begin
    state_nx   = state;
    byte_ready = state == LEN || state == DATA;
    we         = state == WRITE;
    busy       = byte_ready || we;
    cpu_hold   = busy;
    done       = state == DONE;
    err        = state == ERR;
    case (state)
      IDLE, DONE, ERR: state_nx = start ? LEN : state;
      LEN:             state_nx = tmo ? ERR : !xfer ? LEN : len_bad ? ERR : DATA;
      DATA:            state_nx = tmo ? ERR : (xfer && nbytes == 2'd3) ? WRITE : DATA;
      WRITE:           state_nx = last ? DONE : DATA;
      default:         state_nx = IDLE;
    endcase
  end
  // word assembly, addressing, word count and idle timer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      total      <= '0;
      nbytes     <= '0;
      idle       <= '0;
      waddr      <= '0;
      wdata      <= '0;
      word_count <= '0;
    end else if (go) begin
      nbytes     <= '0;
      idle       <= '0;
      waddr      <= '0;
      word_count <= '0;
    end else begin
      idle <= (xfer || !(state == LEN || state == DATA)) ? '0 : idle + TW'(1);
      if (state == LEN && xfer)
        total <= byte_data == 8'd0 ? (ADDR_W + 1)'(CAP) : (ADDR_W + 1)'(byte_data);
      if (state == DATA && xfer) begin
        wdata  <= {wdata[23:0], byte_data};
        nbytes <= nbytes + 2'd1;
      end
      if (state == WRITE) begin
        word_count <= word_count + (ADDR_W + 1)'(1);
        if (!last) waddr <= waddr + ADDR_W'(1);
      end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table-driven and randomized checks of inst_loader against a word-level model
module tb_inst_loader;
  localparam int AW = 6;
  localparam int TO = 16;
  logic clk = 0, rst = 0, start = 0, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, we, cpu_hold, busy, done, err;
  logic [AW-1:0] waddr;
  logic [31:0] wdata;
  logic [AW:0] word_count;
  int n_total = 0, n_bad = 0, cyc = 0;
  int last_xfer = 0, end_cyc = 0;
  bit hold_ok;
  typedef struct {int addr; logic [31:0] data; int cyc;} wr_t;
  wr_t wq[$];
  logic [7:0] stream[$];
  logic [7:0] fixed_bytes[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  typedef struct {logic [7:0] n; int nd; int vp; bit edone; bit eerr; int ecount; int elat;} vec_t;
  vec_t tbl[9];

  inst_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // write monitor: record every RAM write mid-cycle
  always @(negedge clk) if (rst && we) begin
    wq.push_back('{int'(waddr), wdata, cyc});
    chk("ready_in_write", int'(byte_ready), 0);
  end

  task automatic load(input logic [7:0] n, input int nd, input int vp, input bit wait_end, input bit fixed);
    int idx;
    bit v, r;
    stream = {};
    stream.push_back(n);
    for (int i = 0; i < nd; i++) stream.push_back(fixed ? fixed_bytes[i % 8] : 8'($urandom));
    wq = {};
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("len_ready", int'(byte_ready), 1);
    chk("len_hold", int'(cpu_hold), 1);
    idx = 0;
    hold_ok = 1;
    for (int c = 0; c < 5000 && idx < stream.size() && !done && !err; c++) begin
      v = $urandom_range(99) < vp;
      r = byte_ready;
      if (!cpu_hold) hold_ok = 0;
      byte_valid = v;
      byte_data = stream[idx];
      start = (vp < 100) ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
      if (v && r) begin
        idx++;
        last_xfer = cyc;
      end
    end
    byte_valid = 0;
    start = 0;
    if (wait_end) begin
      for (int c = 0; c < 200 && !done && !err; c++) begin
        if (!cpu_hold) hold_ok = 0;
        @(posedge clk); #1;
      end
      end_cyc = cyc;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_flags"}, int'({byte_ready, we, cpu_hold, busy, done, err}), 0);
    chk({tag, "_waddr"}, int'(waddr), 0);
    chk({tag, "_wdata"}, int'(wdata), 0);
    chk({tag, "_count"}, int'(word_count), 0);
  endtask

  initial begin
    int tw, nw;
    logic [31:0] ew;
    tbl[0] = '{8'd2,   8,   100, 1, 0, 2,  1};
    tbl[1] = '{8'd2,   8,   50,  1, 0, 2,  1};
    tbl[2] = '{8'd0,   256, 100, 1, 0, 64, 1};
    tbl[3] = '{8'd65,  0,   100, 0, 1, 0,  0};
    tbl[4] = '{8'd1,   2,   100, 0, 1, 0,  16};
    tbl[5] = '{8'd64,  256, 60,  1, 0, 64, 1};
    tbl[6] = '{8'd3,   7,   100, 0, 1, 1,  16};
    tbl[7] = '{8'd255, 0,   100, 0, 1, 0,  0};
    tbl[8] = '{8'd1,   4,   70,  1, 0, 1,  1};
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1;
    byte_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ignores_valid", int'(byte_ready), 0);
    byte_valid = 0;

    load(8'd2, 8, 100, 1, 1);
    chk("fixed_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("fixed_addr0", wq[0].addr, 0);
      chk("fixed_data0", int'(wq[0].data), int'(32'h12345678));
      chk("fixed_addr1", wq[1].addr, 1);
      chk("fixed_data1", int'(wq[1].data), int'(32'h9ABCDEF0));
    end
    chk("fixed_done", int'(done), 1);
    chk("fixed_count", int'(word_count), 2);
    chk("fixed_hold_during", int'(hold_ok), 1);
    chk("fixed_hold_release", int'(cpu_hold), 0);

    for (int t = 0; t < 9; t++) begin
      load(tbl[t].n, tbl[t].nd, tbl[t].vp, 1, 0);
      tw = (tbl[t].n == 0) ? 64 : int'(tbl[t].n);
      nw = (tw > 64) ? 0 : (tbl[t].nd / 4 < tw ? tbl[t].nd / 4 : tw);
      chk($sformatf("v%0d_done", t), int'(done), int'(tbl[t].edone));
      chk($sformatf("v%0d_err", t), int'(err), int'(tbl[t].eerr));
      chk($sformatf("v%0d_count", t), int'(word_count), tbl[t].ecount);
      chk($sformatf("v%0d_lat", t), end_cyc - last_xfer, tbl[t].elat);
      chk($sformatf("v%0d_hold", t), int'(hold_ok), 1);
      chk($sformatf("v%0d_release", t), int'(cpu_hold), 0);
      chk($sformatf("v%0d_nwrites", t), wq.size(), nw);
      for (int i = 0; i < nw && i < wq.size(); i++) begin
        ew = {stream[1 + 4 * i], stream[2 + 4 * i], stream[3 + 4 * i], stream[4 + 4 * i]};
        chk($sformatf("v%0d_addr%0d", t, i), wq[i].addr, i);
        chk($sformatf("v%0d_data%0d", t, i), int'(wq[i].data), int'(ew));
        if (i > 0 && tbl[t].vp == 100)
          chk($sformatf("v%0d_gap%0d", t, i), wq[i].cyc - wq[i - 1].cyc, 5);
      end
    end

    load(8'd2, 6, 100, 0, 0);
    #2 rst = 0;
    #1;
    check_reset_values("midword_rst");
    @(posedge clk); #1;
    rst = 1;
    load(8'd1, 4, 100, 1, 1);
    chk("after_rst_nwrites", wq.size(), 1);
    if (wq.size() == 1) begin
      chk("after_rst_addr", wq[0].addr, 0);
      chk("after_rst_data", int'(wq[0].data), int'(32'h12345678));
    end
    chk("after_rst_done", int'(done), 1);

    load(8'd1, 4, 100, 0, 0);
    chk("write_pending_we", int'(we), 1);
    #1 rst = 0;
    #1;
    check_reset_values("write_rst");
    @(posedge clk); #1;
    rst = 1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
